// File: rtl/vga_timing_pipe.sv
// VGA raster timing generator with a pixel-enable at clk/2.
// Sync and blank flags are delayed to line up with the compositor's color latency.
module vga_timing_pipe #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int COLOR_LAT = 0
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic [23:0] color_in,
    output logic [9:0]  VGA_row,
    output logic [9:0]  VGA_col,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        VGA_CLK,
    output logic        frame_tick
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    // Flag bundle order: {active, hs, vs}; idle is blank with both syncs high.
    localparam logic [2:0] FLAGS_IDLE = 3'b011;

    logic       phase;
    logic       pix_en;
    logic [9:0] col;
    logic [9:0] row;
    logic [9:0] col_next;
    logic [9:0] row_next;
    logic [2:0] flags_raw;
    logic [2:0] flags_dly;

    assign pix_en = phase;

    always_comb begin
        col_next = col + 10'd1;
        row_next = row;
        if (col == H_LAST) begin
            col_next = '0;
            row_next = (row == V_LAST) ? '0 : row + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            phase      <= 1'b0;
            VGA_CLK    <= 1'b0;
            col        <= '0;
            row        <= '0;
            frame_tick <= 1'b0;
        end else begin
            phase      <= ~phase;
            VGA_CLK    <= pix_en;
            frame_tick <= pix_en && (row_next == V_VIS) && (col_next == '0);
            if (pix_en) begin
                col <= col_next;
                row <= row_next;
            end
        end
    end

    assign flags_raw[2] = (col < H_VIS) && (row < V_VIS);
    assign flags_raw[1] = !((col >= HS_START) && (col < HS_END));
    assign flags_raw[0] = !((row >= VS_START) && (row < VS_END));

    generate
        if (COLOR_LAT == 0) begin : g_nodelay
            assign flags_dly = flags_raw;
        end else begin : g_delay
            logic [2:0] stage [COLOR_LAT];

            always_ff @(posedge clk or negedge rst_l) begin
                if (!rst_l) begin
                    for (int i = 0; i < COLOR_LAT; i++) stage[i] <= FLAGS_IDLE;
                end else if (pix_en) begin
                    stage[0] <= flags_raw;
                    for (int i = 1; i < COLOR_LAT; i++) stage[i] <= stage[i-1];
                end
            end

            assign flags_dly = stage[COLOR_LAT-1];
        end
    endgenerate

    // color_in already carries COLOR_LAT periods of delay, so it pairs with flags_dly.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else if (pix_en) begin
            VGA_BLANK_N           <= flags_dly[2];
            VGA_HS                <= flags_dly[1];
            VGA_VS                <= flags_dly[0];
            {VGA_R, VGA_G, VGA_B} <= flags_dly[2] ? color_in : 24'h0;
        end
    end

    assign VGA_row    = row;
    assign VGA_col    = col;
    assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Directed bench: default timing at COLOR_LAT 0 and 2, plus a reduced raster
// (24x15, COLOR_LAT 1) for frame, vertical sync, wrap and mid-frame reset.
module tb_vga_timing_pipe;
    logic clk = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rel_cyc = 0;
    logic chk_on = 1'b0;
    int ticks[$];

    // Instance a: defaults, COLOR_LAT=0
    logic [23:0] a_color;
    logic [9:0]  a_row, a_col;
    logic [7:0]  a_r, a_g, a_b;
    logic        a_hs, a_vs, a_bl, a_sy, a_vclk, a_tick;
    // Instance b: defaults, COLOR_LAT=2
    logic [23:0] b_color, b_c1, b_c2;
    logic [9:0]  b_row, b_col;
    logic [7:0]  b_r, b_g, b_b;
    logic        b_hs, b_vs, b_bl, b_sy, b_vclk, b_tick;
    // Instance s: small raster, COLOR_LAT=1
    logic [23:0] s_color;
    logic [9:0]  s_row, s_col;
    logic [7:0]  s_r, s_g, s_b;
    logic        s_hs, s_vs, s_bl, s_sy, s_vclk, s_tick;

    assign a_color = 24'hFF00FF;
    assign s_color = 24'h3C96E1;
    assign b_color = b_c2;

    vga_timing_pipe #(.COLOR_LAT(0)) u_a (
        .clk(clk), .rst_l(rst_l), .color_in(a_color),
        .VGA_row(a_row), .VGA_col(a_col), .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b),
        .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK_N(a_bl), .VGA_SYNC_N(a_sy),
        .VGA_CLK(a_vclk), .frame_tick(a_tick));

    vga_timing_pipe #(.COLOR_LAT(2)) u_b (
        .clk(clk), .rst_l(rst_l), .color_in(b_color),
        .VGA_row(b_row), .VGA_col(b_col), .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b),
        .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_bl), .VGA_SYNC_N(b_sy),
        .VGA_CLK(b_vclk), .frame_tick(b_tick));

    vga_timing_pipe #(.H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                      .V_VISIBLE(10), .V_FP(1), .V_SYNC(2), .V_BP(2),
                      .COLOR_LAT(1)) u_s (
        .clk(clk), .rst_l(rst_l), .color_in(s_color),
        .VGA_row(s_row), .VGA_col(s_col), .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b),
        .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_BLANK_N(s_bl), .VGA_SYNC_N(s_sy),
        .VGA_CLK(s_vclk), .frame_tick(s_tick));

    // Compositor model for b: its own pixel phase and a 2-stage registered color path.
    logic tb_ph;
    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) tb_ph <= 1'b0;
        else        tb_ph <= ~tb_ph;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_l && tb_ph) begin
            b_c1 <= {b_row[7:0], b_col[7:0], 8'h00};
            b_c2 <= b_c1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pins now reflect the counter position lat+1 pixels before the shown counter.
    task automatic pix_check(input string nm, input int r, input int c, input int lat,
                             input int hv, input int hfp, input int hsy, input int hbp,
                             input int vv, input int vfp, input int vsy, input int vbp,
                             input int cmode, input logic [23:0] cconst,
                             input logic hs, input logic vs, input logic bl,
                             input logic [23:0] rgb);
        int ht, vt, idx, pr, pc;
        logic act;
        logic [7:0] pr8, pc8;
        logic [23:0] exp_rgb;
        ht = hv + hfp + hsy + hbp;
        vt = vv + vfp + vsy + vbp;
        idx = r * ht + c - (lat + 1);
        if (idx < 0) idx += ht * vt;
        pr = idx / ht;
        pc = idx % ht;
        pr8 = pr[7:0];
        pc8 = pc[7:0];
        act = (pc < hv) && (pr < vv);
        if (!act)          exp_rgb = 24'h0;
        else if (cmode==1) exp_rgb = {pr8, pc8, 8'h00};
        else               exp_rgb = cconst;
        check({nm, "_blank"}, bl, act);
        check({nm, "_hs"}, hs, !((pc >= hv + hfp) && (pc < hv + hfp + hsy)));
        check({nm, "_vs"}, vs, !((pr >= vv + vfp) && (pr < vv + vfp + vsy)));
        check({nm, "_rgb"}, rgb, exp_rgb);
    endtask

    task automatic rst_vals(input string nm, input logic [9:0] r, input logic [9:0] c,
                            input logic hs, input logic vs, input logic bl,
                            input logic [23:0] rgb, input logic tk, input logic vc,
                            input logic sy);
        check({nm, "_rst_row"}, r, 0);
        check({nm, "_rst_col"}, c, 0);
        check({nm, "_rst_hs"}, hs, 1);
        check({nm, "_rst_vs"}, vs, 1);
        check({nm, "_rst_blank"}, bl, 0);
        check({nm, "_rst_rgb"}, rgb, 0);
        check({nm, "_rst_tick"}, tk, 0);
        check({nm, "_rst_vclk"}, vc, 0);
        check({nm, "_sync_n"}, sy, 0);
    endtask

    logic       hs_prev, vs_prev, bl_prev, tick_prev, have_prev;
    int         hs_cnt, vs_cnt;
    logic [9:0] prev_r, prev_c;
    logic [9:0] exp_r, exp_c;

    always_comb begin
        exp_r = prev_r;
        exp_c = prev_c + 10'd1;
        if (prev_c == 10'd23) begin
            exp_c = 10'd0;
            exp_r = (prev_r == 10'd14) ? 10'd0 : prev_r + 10'd1;
        end
    end

    always @(negedge clk) begin
        if (!chk_on) begin
            hs_prev <= 1'b1; vs_prev <= 1'b1; bl_prev <= 1'b0; tick_prev <= 1'b0;
            have_prev <= 1'b0; hs_cnt <= 0; vs_cnt <= 0; prev_r <= '0; prev_c <= '0;
        end else begin
            if (s_tick) begin
                check("tick_pos", {s_row, s_col}, {10'd10, 10'd0});
                check("tick_width", tick_prev, 0);
                ticks.push_back(cyc - rel_cyc);
            end
            tick_prev <= s_tick;
            if (a_vclk) begin
                pix_check("a", a_row, a_col, 0, 640, 16, 96, 48, 480, 10, 2, 33,
                          0, 24'hFF00FF, a_hs, a_vs, a_bl, {a_r, a_g, a_b});
                pix_check("b", b_row, b_col, 2, 640, 16, 96, 48, 480, 10, 2, 33,
                          1, 24'h0, b_hs, b_vs, b_bl, {b_r, b_g, b_b});
                pix_check("s", s_row, s_col, 1, 16, 2, 3, 3, 10, 1, 2, 2,
                          0, 24'h3C96E1, s_hs, s_vs, s_bl, {s_r, s_g, s_b});
                if (hs_prev && !a_hs) begin
                    check("hs_start", a_col, 657);
                    hs_cnt <= 1;
                end else if (!a_hs) hs_cnt <= hs_cnt + 1;
                if (!hs_prev && a_hs) check("hs_width", hs_cnt, 96);
                if (vs_prev && !s_vs) begin
                    check("vs_start", {s_row, s_col}, {10'd11, 10'd2});
                    vs_cnt <= 1;
                end else if (!s_vs) vs_cnt <= vs_cnt + 1;
                if (!vs_prev && s_vs) check("vs_width", vs_cnt, 48);
                if (have_prev) check("s_seq", {s_row, s_col}, {exp_r, exp_c});
                if (!bl_prev && s_bl && s_row == 10'd0) check("blank_rise", s_col, 2);
                hs_prev <= a_hs; vs_prev <= s_vs; bl_prev <= s_bl;
                prev_r <= s_row; prev_c <= s_col; have_prev <= 1'b1;
            end
        end
    end

    initial begin
        int early;
        bit found;
        $display("step: reset hold");
        repeat (3) @(negedge clk);
        rst_vals("a", a_row, a_col, a_hs, a_vs, a_bl, {a_r, a_g, a_b}, a_tick, a_vclk, a_sy);
        rst_vals("b", b_row, b_col, b_hs, b_vs, b_bl, {b_r, b_g, b_b}, b_tick, b_vclk, b_sy);
        rst_vals("s", s_row, s_col, s_hs, s_vs, s_bl, {s_r, s_g, s_b}, s_tick, s_vclk, s_sy);

        $display("step: release reset, free run");
        rel_cyc = cyc;
        rst_l = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);
        check("rel_col0", s_col, 0);
        check("rel_vclk0", s_vclk, 0);
        @(negedge clk);
        check("rel_col1", {a_row, a_col}, {10'd0, 10'd1});
        check("rel_vclk1", a_vclk, 1);
        repeat (3400) @(negedge clk);

        $display("step: frame tick summary, %0d ticks", ticks.size());
        early = 0;
        foreach (ticks[i]) if (ticks[i] < 720) early++;
        check("tick_one_per_frame", early, 1);
        check("tick_count", ticks.size(), 5);
        if (ticks.size() >= 2) begin
            check("tick_first", ticks[0], 480);
            check("tick_period", ticks[1] - ticks[0], 720);
        end else begin
            check("tick_seen", ticks.size(), 2);
        end

        $display("step: mid-frame reset");
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (s_row == 10'd5 && s_col == 10'd7) found = 1'b1;
        end
        check("reach_mid", found, 1);
        #2;
        chk_on = 1'b0;
        rst_l = 1'b0;
        #1;
        rst_vals("a", a_row, a_col, a_hs, a_vs, a_bl, {a_r, a_g, a_b}, a_tick, a_vclk, a_sy);
        rst_vals("b", b_row, b_col, b_hs, b_vs, b_bl, {b_r, b_g, b_b}, b_tick, b_vclk, b_sy);
        rst_vals("s", s_row, s_col, s_hs, s_vs, s_bl, {s_r, s_g, s_b}, s_tick, s_vclk, s_sy);
        repeat (2) @(negedge clk);

        $display("step: restart");
        rel_cyc = cyc;
        rst_l = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);
        check("restart_pos0", {s_row, s_col}, {10'd0, 10'd0});
        check("restart_tick", s_tick, 0);
        @(negedge clk);
        check("restart_pos1", {s_row, s_col}, {10'd0, 10'd1});
        repeat (800) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
